key_sequence_sender: RTL and testbench

//  Transmit side of the three-button keypad entry interface (btn0/btn1/btnEntry, all active-low).

---
 rtl/key_sequence_sender.sv | 187 ++++++++++++++++++
 tb/tb_key_sequence_sender.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_sequence_sender.sv
// rtl/key_sequence_sender.sv - replays a latched code MSB-first as keypad presses and captures the verdict
// Optional macro KEY_SEQ_CHECK_EN adds a mismatch output comparing the verdict with popcount(code) >= 2.
module key_sequence_sender #(
  parameter int NBITS        = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int ENTRY_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic             btn0,
  output logic             btn1,
  output logic             btnEntry,
  input  logic             ledLight,
  output logic             busy,
  output logic             done,
  output logic             accepted
`ifdef KEY_SEQ_CHECK_EN
  ,
  output logic             mismatch
`endif
);

  localparam int MAXC = (GAP_CYCLES > ENTRY_CYCLES) ? GAP_CYCLES : ENTRY_CYCLES;
  localparam int CW   = (MAXC > 0) ? $clog2(MAXC + 1) : 1;
  localparam int IW   = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LOAD   = IW'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS  = 3'd1,
    S_GAP    = 3'd2,
    S_ENTRY  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NBITS-1:0] r_shift;
  logic [NBITS-1:0] w_shift_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  logic r_btn0;
  logic r_btn1;
  logic r_btn_entry;
  logic r_busy;
  logic r_code_ready;
  logic r_done;
  logic r_accepted;

  logic w_btn0_nxt;
  logic w_btn1_nxt;
  logic w_btn_entry_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;
  logic w_accepted_nxt;
  logic w_last;
  logic w_capture;

  // r_idx is the bit currently on the buttons; it only moves when the next press starts
  assign w_last    = (r_idx == '0);
  assign w_capture = (r_state == S_ENTRY) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_btn0       <= 1'b1;
      r_btn1       <= 1'b1;
      r_btn_entry  <= 1'b1;
      r_busy       <= 1'b0;
      r_code_ready <= 1'b1;
      r_done       <= 1'b0;
      r_accepted   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_btn0       <= w_btn0_nxt;
      r_btn1       <= w_btn1_nxt;
      r_btn_entry  <= w_btn_entry_nxt;
      r_busy       <= w_busy_nxt;
      r_code_ready <= ~w_busy_nxt;
      r_done       <= w_done_nxt;
      r_accepted   <= w_accepted_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (code_valid) begin
          w_state_nxt = S_PRESS;
          w_shift_nxt = code_in;
          w_idx_nxt   = IDX_LOAD;
        end
      end
      S_PRESS: begin
        if (GAP_CYCLES > 0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else if (w_last) begin
          w_state_nxt = S_ENTRY;
          w_cnt_nxt   = ENTRY_LOAD;
        end else begin
          w_state_nxt = S_PRESS;
          w_shift_nxt = r_shift << 1;
          w_idx_nxt   = r_idx - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_ENTRY;
          w_cnt_nxt   = ENTRY_LOAD;
        end else begin
          w_state_nxt = S_PRESS;
          w_shift_nxt = r_shift << 1;
          w_idx_nxt   = r_idx - 1'b1;
        end
      end
      S_ENTRY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = S_RESULT;
        end
      end
      S_RESULT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop
  always_comb begin
    w_btn0_nxt      = ~((w_state_nxt == S_PRESS) && ~w_shift_nxt[NBITS-1]);
    w_btn1_nxt      = ~((w_state_nxt == S_PRESS) && w_shift_nxt[NBITS-1]);
    w_btn_entry_nxt = ~(w_state_nxt == S_ENTRY);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_RESULT);
    w_accepted_nxt  = w_capture ? ledLight : r_accepted;
  end

  assign btn0       = r_btn0;
  assign btn1       = r_btn1;
  assign btnEntry   = r_btn_entry;
  assign busy       = r_busy;
  assign code_ready = r_code_ready;
  assign done       = r_done;
  assign accepted   = r_accepted;

`ifdef KEY_SEQ_CHECK_EN
  logic r_expected;
  logic r_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_expected <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && code_valid) begin
        r_expected <= ($countones(code_in) >= 2);
      end
      r_mismatch <= w_capture && (ledLight != r_expected);
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_key_sequence_sender.sv
// tb/tb_key_sequence_sender.sv - directed bench for key_sequence_sender with a downstream keypad model
// Covers default timing and GAP_CYCLES=0; the mismatch checks build when KEY_SEQ_CHECK_EN is defined.
module tb_key_sequence_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] code_in;
  logic       code_valid;
  logic [3:0] code_in0;
  logic       code_valid0;
  logic       code_ready, btn0, btn1, btnEntry, ledLight, busy, done, accepted;
  logic       code_ready0, btn0_0, btn1_0, btnEntry0, ledLight0, busy0, done0, accepted0;
`ifdef KEY_SEQ_CHECK_EN
  logic       mismatch, mismatch0;
`endif

  int   errors = 0;
  int   checks = 0;
  logic force_low = 1'b0;

  key_sequence_sender dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready),
    .btn0(btn0), .btn1(btn1), .btnEntry(btnEntry), .ledLight(ledLight),
    .busy(busy), .done(done), .accepted(accepted)
`ifdef KEY_SEQ_CHECK_EN
    , .mismatch(mismatch)
`endif
  );

  key_sequence_sender #(.NBITS(4), .GAP_CYCLES(0), .ENTRY_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .code_in(code_in0), .code_valid(code_valid0), .code_ready(code_ready0),
    .btn0(btn0_0), .btn1(btn1_0), .btnEntry(btnEntry0), .ledLight(ledLight0),
    .busy(busy0), .done(done0), .accepted(accepted0)
`ifdef KEY_SEQ_CHECK_EN
    , .mismatch(mismatch0)
`endif
  );

  // Downstream keypad: shifts one digit per low cycle, lights when at least two 1s were entered
  logic [3:0] m_dig, m_dig0;
  logic       m_prev, m_prev0;

  always @(posedge clk) begin
    if (rst) begin
      m_dig <= 4'd0; m_prev <= 1'b1; m_dig0 <= 4'd0; m_prev0 <= 1'b1;
    end else begin
      m_prev  <= btnEntry;
      m_prev0 <= btnEntry0;
      if (btnEntry && !m_prev) m_dig <= 4'd0;
      else if (!btn0) m_dig <= {m_dig[2:0], 1'b0};
      else if (!btn1) m_dig <= {m_dig[2:0], 1'b1};
      if (btnEntry0 && !m_prev0) m_dig0 <= 4'd0;
      else if (!btn0_0) m_dig0 <= {m_dig0[2:0], 1'b0};
      else if (!btn1_0) m_dig0 <= {m_dig0[2:0], 1'b1};
    end
  end

  assign ledLight  = force_low ? 1'b0 : (!btnEntry && ($countones(m_dig) >= 2));
  assign ledLight0 = force_low ? 1'b0 : (!btnEntry0 && ($countones(m_dig0) >= 2));

  typedef struct {
    logic [3:0] code;
    logic       exp_acc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // {btn0, btn1, btnEntry, busy, code_ready, done} expected k cycles after the transfer edge
  function automatic logic [5:0] exp_vec(input int k, input logic [3:0] code, input int gap);
    int   per;
    logic b0, b1, be, dn, bt;
    per = 1 + gap;
    b0 = 1'b1; b1 = 1'b1; be = 1'b1;
    if (k >= 1 && k <= 4 * per && ((k - 1) % per) == 0) begin
      bt = code[3 - (k - 1) / per];
      b0 = bt;
      b1 = ~bt;
    end
    if (k == 4 * per + 1 || k == 4 * per + 2) be = 1'b0;
    dn = (k == 4 * per + 3);
    return {b0, b1, be, 1'b1, 1'b0, dn};
  endfunction

  function automatic logic [5:0] obs(input bit sel);
    if (sel) return {btn0_0, btn1_0, btnEntry0, busy0, code_ready0, done0};
    return {btn0, btn1, btnEntry, busy, code_ready, done};
  endfunction

  task automatic run_seq(input bit sel, input logic [3:0] code, input logic exp_acc,
                         input bit hold, input logic [3:0] next_code);
    int   gap;
    int   last;
    logic exp_mis;
    gap     = sel ? 0 : 2;
    last    = 4 * (1 + gap) + 3;
    exp_mis = exp_acc != ($countones(code) >= 2);
    check($sformatf("ready_before_%b", code), sel ? code_ready0 : code_ready, 1);
    if (sel) begin code_in0 = code; code_valid0 = 1'b1; end
    else begin code_in = code; code_valid = 1'b1; end
    @(posedge clk); #1;
    if (sel) code_valid0 = 1'b0;
    else begin code_in = next_code; code_valid = hold; end
    for (int k = 1; k <= last; k++) begin
      check($sformatf("pins_%b_g%0d_c%0d", code, gap, k), obs(sel), exp_vec(k, code, gap));
      if (k == last) begin
        check($sformatf("accepted_%b_g%0d", code, gap), sel ? accepted0 : accepted, exp_acc);
`ifdef KEY_SEQ_CHECK_EN
        check($sformatf("mismatch_%b_g%0d", code, gap), sel ? mismatch0 : mismatch, exp_mis);
`endif
      end
      @(posedge clk); #1;
    end
    check($sformatf("idle_after_%b_g%0d", code, gap),
          sel ? {busy0, code_ready0, done0, accepted0} : {busy, code_ready, done, accepted},
          {1'b0, 1'b1, 1'b0, exp_acc});
  endtask

  initial begin
    int n_done;
    vecs[0] = '{4'b1010, 1'b1};
    vecs[1] = '{4'b0001, 1'b0};
    vecs[2] = '{4'b0011, 1'b1};
    vecs[3] = '{4'b0000, 1'b0};
    vecs[4] = '{4'b0110, 1'b1};
    vecs[5] = '{4'b1111, 1'b1};

    rst = 1'b1; code_in = 4'd0; code_valid = 1'b0; code_in0 = 4'd0; code_valid0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut", {obs(1'b0), accepted}, 7'b1110100);
    check("reset_dut0", {obs(1'b1), accepted0}, 7'b1110100);
`ifdef KEY_SEQ_CHECK_EN
    check("reset_mismatch", {mismatch, mismatch0}, 2'b00);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_seq(1'b0, vecs[i].code, vecs[i].exp_acc, 1'b0, 4'd0);

    // code_valid held with a second code throughout the first sequence
    run_seq(1'b0, 4'b1010, 1'b1, 1'b1, 4'b0001);
    run_seq(1'b0, 4'b0001, 1'b0, 1'b0, 4'd0);

    // reset during the second gap, with accepted=1 left from the previous run
    run_seq(1'b0, 4'b0011, 1'b1, 1'b0, 4'd0);
    code_in = 4'b1010; code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("rst_pre_c%0d", k), obs(1'b0), exp_vec(k, 4'b1010, 2));
      if (k < 5) begin @(posedge clk); #1; end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_state", {obs(1'b0), accepted}, 7'b1110100);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    check("rst_no_done", n_done, 0);
    run_seq(1'b0, 4'b1001, 1'b1, 1'b0, 4'd0);

    run_seq(1'b1, 4'b1111, 1'b1, 1'b0, 4'd0);
    run_seq(1'b1, 4'b0100, 1'b0, 1'b0, 4'd0);
    run_seq(1'b1, 4'b0101, 1'b1, 1'b0, 4'd0);

`ifdef KEY_SEQ_CHECK_EN
    force_low = 1'b1;
    run_seq(1'b0, 4'b1100, 1'b0, 1'b0, 4'd0);
    force_low = 1'b0;
    run_seq(1'b0, 4'b1100, 1'b1, 1'b0, 4'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
